// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider: quotient to lo, remainder to hi.
// Holds the pipeline via stall while an operation is in PREP or RUN.
module div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_signed,
   input  logic             cancel,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             stall,
   output logic             busy,
   output logic             valid,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {IDLE, PREP, RUN, DONE} state_t;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg;
   logic [WIDTH-1:0] a_reg, b_reg, quo_reg;
   logic [WIDTH:0]   rem_reg, dvs_reg;
   logic             signed_reg, neg_q_reg, neg_r_reg;

   logic             accept;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH:0]   b_mag;
   logic [WIDTH+1:0] shifted, diff;
   logic             ge;
   logic [WIDTH:0]   rem_step;
   logic [WIDTH-1:0] quo_step, lo_fin, hi_fin;

   assign accept = start & (state_reg == IDLE) & ~cancel;
   assign stall  = accept | (state_reg == PREP) | (state_reg == RUN);

   // Magnitudes; the divisor keeps an extra bit so |most-negative| is exact.
   assign a_mag = (signed_reg & a_reg[WIDTH-1]) ? -a_reg : a_reg;
   assign b_mag = (signed_reg & b_reg[WIDTH-1]) ? -{1'b1, b_reg} : {1'b0, b_reg};

   // One restoring step: shift in the next dividend bit, trial subtract.
   assign shifted  = {rem_reg, quo_reg[WIDTH-1]};
   assign diff     = shifted - {1'b0, dvs_reg};
   assign ge       = ~diff[WIDTH+1];
   assign rem_step = ge ? diff[WIDTH:0] : shifted[WIDTH:0];
   assign quo_step = {quo_reg[WIDTH-2:0], ge};

   // Divide by zero bypasses sign correction entirely.
   always_comb begin
      lo_fin = neg_q_reg ? -quo_step : quo_step;
      hi_fin = neg_r_reg ? -rem_step[WIDTH-1:0] : rem_step[WIDTH-1:0];
      if (dvs_reg == '0) begin
         lo_fin = '1;
         hi_fin = a_reg;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept) state_next = PREP;
         PREP:    state_next = cancel ? IDLE : RUN;
         RUN: begin
            if (cancel)                    state_next = IDLE;
            else if (cnt_reg == CNT_W'(1)) state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         busy       <= 1'b0;
         valid      <= 1'b0;
         hi         <= '0;
         lo         <= '0;
         a_reg      <= '0;
         b_reg      <= '0;
         quo_reg    <= '0;
         rem_reg    <= '0;
         dvs_reg    <= '0;
         signed_reg <= 1'b0;
         neg_q_reg  <= 1'b0;
         neg_r_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         busy      <= (state_next == PREP) || (state_next == RUN);
         valid     <= (state_next == DONE);
         if (accept) begin
            a_reg      <= a;
            b_reg      <= b;
            signed_reg <= is_signed;
         end
         if (state_reg == PREP) begin
            quo_reg   <= a_mag;
            dvs_reg   <= b_mag;
            rem_reg   <= '0;
            neg_q_reg <= signed_reg & (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
            neg_r_reg <= signed_reg & a_reg[WIDTH-1];
            cnt_reg   <= CNT_W'(WIDTH);
         end
         if (state_reg == RUN && !cancel) begin
            rem_reg <= rem_step;
            quo_reg <= quo_step;
            cnt_reg <= cnt_reg - CNT_W'(1);
            if (cnt_reg == CNT_W'(1)) begin
               hi <= hi_fin;
               lo <= lo_fin;
            end
         end
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: timeline-based reference model with per-cycle compare,
// directed corner cases and randomized start/cancel/reset traffic.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst, start, is_signed, cancel;
   logic [31:0] a, b;
   logic        stall, busy, valid;
   logic [31:0] hi, lo;

   div_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk(clk), .rst(rst), .start(start), .is_signed(is_signed), .cancel(cancel),
      .a(a), .b(b), .stall(stall), .busy(busy), .valid(valid), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
      end
   endtask

   // Reference result {hi, lo} from plain integer arithmetic.
   function automatic logic [63:0] ref_div(input logic s, input logic [31:0] x, input logic [31:0] y);
      int sx, sy;
      if (y == 0) return {x, 32'hFFFF_FFFF};
      if (s) begin
         if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
         sx = x;
         sy = y;
         return {32'(sx % sy), 32'(sx / sy)};
      end
      return {x % y, x / y};
   endfunction

   // Model: an accepted start in cycle t0 is busy t0+1..t0+33, valid in t0+34.
   int          cyc = 0;
   int          t0 = 0;
   bit          pend = 0;
   bit          chk = 0;
   logic [31:0] m_hi = '0, m_lo = '0, p_hi, p_lo;

   always @(posedge clk) begin
      if (rst) begin
         pend = 0;
         m_hi = '0;
         m_lo = '0;
         chk  = 1;
      end else if (pend) begin
         if (cyc >= t0 + 1 && cyc <= t0 + 33 && cancel) pend = 0;
         else if (cyc == t0 + 33) begin
            m_hi = p_hi;
            m_lo = p_lo;
         end else if (cyc == t0 + 34) pend = 0;
      end else if (start && !cancel) begin
         pend = 1;
         t0   = cyc;
         {p_hi, p_lo} = ref_div(is_signed, a, b);
      end
      cyc++;
   end

   always @(negedge clk) begin
      logic busy_e, valid_e, stall_e;
      if (chk) begin
         busy_e  = pend && cyc >= t0 + 1 && cyc <= t0 + 33;
         valid_e = pend && cyc == t0 + 34;
         stall_e = busy_e || (!pend && start && !cancel);
         cmp("stall", 64'(stall), 64'(stall_e));
         cmp("busy",  64'(busy),  64'(busy_e));
         cmp("valid", 64'(valid), 64'(valid_e));
         cmp("hi",    64'(hi),    64'(m_hi));
         cmp("lo",    64'(lo),    64'(m_lo));
         if (valid) $display("txn cyc=%0d hi=%h lo=%h", cyc, hi, lo);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic s, input logic [31:0] x, input logic [31:0] y);
      tick();
      start = 1'b1; is_signed = s; a = x; b = y;
      tick();
      start = 1'b0;
   endtask

   // Called at cycle n0 of an operation; returns the cycle index of valid.
   task automatic wait_valid(input int n0, output int n);
      n = n0;
      while (n < 80) begin
         @(negedge clk);
         if (valid) break;
         tick();
         n++;
      end
   endtask

   task automatic run_op(input string name, input logic s, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp_lo, input logic [31:0] exp_hi);
      int n;
      issue(s, x, y);
      wait_valid(1, n);
      cmp({name, "_lat"}, 64'(n), 64'd34);
      cmp({name, "_lo"},  64'(lo), 64'(exp_lo));
      cmp({name, "_hi"},  64'(hi), 64'(exp_hi));
   endtask

   function automatic logic [31:0] pick();
      case ($urandom % 8)
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom % 16);
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int n, nv;
      rst = 1'b1; start = 1'b0; is_signed = 1'b0; cancel = 1'b0; a = '0; b = '0;
      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      cmp("rst_busy", 64'(busy), 64'd0);
      cmp("rst_lo",   64'(lo),   64'd0);

      cmp("model_u",  ref_div(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
      cmp("model_s",  ref_div(1'b1, 32'hFFFF_FFF9, 32'd2), {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      cmp("model_dz", ref_div(1'b1, 32'hFFFF_FFF0, 32'd0), {32'hFFFF_FFF0, 32'hFFFF_FFFF});

      run_op("divu",  1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
      run_op("div",   1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
      run_op("divu2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1);
      run_op("ovf",   1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
      run_op("dz",    1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);

      // Cancel on cycle 10 of an operation.
      issue(1'b0, 32'd1000, 32'd3);
      repeat (9) tick();
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      @(negedge clk);
      cmp("cancel_busy", 64'(busy), 64'd0);
      cmp("cancel_hi",   64'(hi),   64'd5);
      cmp("cancel_lo",   64'(lo),   64'hFFFF_FFFF);
      nv = 0;
      repeat (40) begin
         tick();
         @(negedge clk);
         if (valid) nv++;
      end
      cmp("cancel_noval", 64'(nv), 64'd0);

      // start and cancel together in IDLE.
      tick();
      start = 1'b1; cancel = 1'b1; a = 32'd50; b = 32'd5;
      tick();
      start = 1'b0; cancel = 1'b0;
      @(negedge clk);
      cmp("coll_busy", 64'(busy), 64'd0);

      // Start during RUN is ignored; next start accepted right after DONE.
      issue(1'b0, 32'd200, 32'd10);
      repeat (13) tick();
      start = 1'b1; a = 32'd7; b = 32'd7;
      tick();
      start = 1'b0;
      wait_valid(15, n);
      cmp("ign_lat", 64'(n), 64'd34);
      cmp("ign_lo",  64'(lo), 64'd20);
      cmp("ign_hi",  64'(hi), 64'd0);
      run_op("b2b", 1'b0, 32'd77, 32'd7, 32'd11, 32'd0);

      // Reset on cycle 20 of an operation.
      issue(1'b1, 32'd12345, 32'd17);
      repeat (19) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      cmp("mrst_hi",    64'(hi),    64'd0);
      cmp("mrst_lo",    64'(lo),    64'd0);
      cmp("mrst_busy",  64'(busy),  64'd0);
      cmp("mrst_valid", 64'(valid), 64'd0);
      run_op("post_rst", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0);

      // Randomized traffic checked by the per-cycle model.
      for (int i = 0; i < 3000; i++) begin
         tick();
         start     = ($urandom % 6) == 0;
         cancel    = ($urandom % 50) == 0;
         rst       = ($urandom % 1500) == 0;
         is_signed = 1'($urandom);
         a         = pick();
         b         = pick();
      end
      tick();
      start = 1'b0; cancel = 1'b0; rst = 1'b0;
      repeat (40) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
